regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto one registered regfile write port (1-cycle latency) and tracks pending destinations.
// Backpressure: the loser of a dual request sees ready=0 and must hold its request until it is granted.
module regfile_wb_arbiter #(
  parameter int n = 32,
  parameter int r = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         aValid,
  input  logic [r-1:0] aReg,
  input  logic [n-1:0] aData,
  output logic         aReady,
  input  logic         bValid,
  input  logic [r-1:0] bReg,
  input  logic [n-1:0] bData,
  output logic         bReady,
  input  logic         issueValid,
  input  logic [r-1:0] issueReg,
  input  logic [r-1:0] queryReg1,
  input  logic [r-1:0] queryReg2,
  output logic         busy1,
  output logic         busy2,
  output logic         regWrite,
  output logic [r-1:0] writeReg,
  output logic [n-1:0] writeData
);

  localparam int NREG = 1 << r;

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

  pri_t            state, state_nxt;
  logic [NREG-1:0] pend, pend_nxt;
  logic            acc;
  logic [r-1:0]    acc_reg;
  logic [n-1:0]    acc_data;

  always_ff @(posedge clk) begin
    if (reset) state <= PRI_A;
    else       state <= state_nxt;
  end

  // The requester just served drops to lower priority; idle cycles keep the order.
  always_comb begin
    state_nxt = state;
    if (aReady)      state_nxt = PRI_B;
    else if (bReady) state_nxt = PRI_A;
  end

  always_comb begin
    aReady = 1'b0;
    bReady = 1'b0;
    if (!reset) begin
      if (aValid && (!bValid || state == PRI_A)) aReady = 1'b1;
      else if (bValid)                           bReady = 1'b1;
    end
  end

  assign acc      = aReady | bReady;
  assign acc_reg  = aReady ? aReg  : bReg;
  assign acc_data = aReady ? aData : bData;

  // Register 0 is hardwired: its writes are acknowledged but never presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      regWrite <= acc && (acc_reg != '0);
      if (acc && (acc_reg != '0)) begin
        writeReg  <= acc_reg;
        writeData <= acc_data;
      end
    end
  end

  // Set is applied after clear so a re-issued destination stays pending.
  always_comb begin
    pend_nxt = pend;
    if (regWrite)                          pend_nxt[writeReg] = 1'b0;
    if (issueValid && (issueReg != '0))    pend_nxt[issueReg] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pend_nxt;
  end

  assign busy1 = pend[queryReg1];
  assign busy2 = pend[queryReg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter with a queue of expected writeback beats.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        aValid, bValid, issueValid;
  logic [6:0]  aReg, bReg, issueReg, queryReg1, queryReg2;
  logic [31:0] aData, bData;
  logic        aReady, bReady, busy1, busy2, regWrite;
  logic [6:0]  writeReg;
  logic [31:0] writeData;

  regfile_wb_arbiter #(.n(32), .r(7)) dut (
    .clk(clk), .reset(reset),
    .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
    .issueValid(issueValid), .issueReg(issueReg),
    .queryReg1(queryReg1), .queryReg2(queryReg2),
    .busy1(busy1), .busy2(busy2),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av; logic [6:0] ar; logic [31:0] ad;
    logic        bv; logic [6:0] br; logic [31:0] bd;
    logic        iv; logic [6:0] ir;
    logic [6:0]  q1; logic [6:0] q2;
    logic        ea; logic eb; logic e1; logic e2;
  } vec_t;

  typedef struct packed {
    logic [6:0]  rg;
    logic [31:0] dt;
  } wr_t;

  wr_t         exp_q[$];
  logic [6:0]  last_reg;
  logic [31:0] last_data;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[21];

  function automatic vec_t mk(
    input logic av, input logic [6:0] ar, input logic [31:0] ad,
    input logic bv, input logic [6:0] br, input logic [31:0] bd,
    input logic iv, input logic [6:0] ir,
    input logic [6:0] q1, input logic [6:0] q2,
    input logic ea, input logic eb, input logic e1, input logic e2);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.iv = iv; v.ir = ir; v.q1 = q1; v.q2 = q2;
    v.ea = ea; v.eb = eb; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    aValid = v.av; aReg = v.ar; aData = v.ad;
    bValid = v.bv; bReg = v.br; bData = v.bd;
    issueValid = v.iv; issueReg = v.ir;
    queryReg1 = v.q1; queryReg2 = v.q2;
  endtask

  // One cycle: check handshake/busy before the edge, then the write port after it.
  task automatic cyc(input string nm, input vec_t v);
    bit  pushed;
    wr_t e;
    drive(v);
    #1;
    chk({nm, ".aReady"}, aReady, v.ea);
    chk({nm, ".bReady"}, bReady, v.eb);
    chk({nm, ".busy1"},  busy1,  v.e1);
    chk({nm, ".busy2"},  busy2,  v.e2);
    pushed = 1'b0;
    if (v.ea && v.ar != 7'd0) begin
      exp_q.push_back({v.ar, v.ad}); pushed = 1'b1;
    end else if (v.eb && v.br != 7'd0) begin
      exp_q.push_back({v.br, v.bd}); pushed = 1'b1;
    end
    @(posedge clk); #1;
    if (pushed) begin
      e = exp_q.pop_front();
      chk({nm, ".regWrite"}, regWrite, 1);
      chk({nm, ".writeReg"}, writeReg, e.rg);
      chk({nm, ".writeData"}, writeData, e.dt);
      last_reg = e.rg; last_data = e.dt;
    end else begin
      chk({nm, ".regWrite"}, regWrite, 0);
      chk({nm, ".writeReg_hold"}, writeReg, last_reg);
      chk({nm, ".writeData_hold"}, writeData, last_data);
    end
  endtask

  initial begin
    //              av ar  ad            bv br  bd           iv ir  q1 q2  ea eb e1 e2
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0,  0,           0, 0,  5, 9,  1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,            0, 0,  0,           0, 0,  5, 9,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,            1, 10, 32'h10,      0, 0,  0, 0,  0, 1, 0, 0);
    tbl[3]  = mk(1, 3, 32'h33,       1, 4,  32'h44,      0, 0,  0, 0,  1, 0, 0, 0);
    tbl[4]  = mk(1, 3, 32'h33,       1, 4,  32'h44,      0, 0,  0, 0,  0, 1, 0, 0);
    tbl[5]  = mk(1, 3, 32'h33,       1, 4,  32'h44,      0, 0,  0, 0,  1, 0, 0, 0);
    tbl[6]  = mk(1, 3, 32'h33,       1, 4,  32'h44,      0, 0,  0, 0,  0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0,            0, 0,  0,           0, 0,  3, 4,  0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0,  0,           1, 9,  9, 0,  0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,            1, 9,  32'h99,      0, 0,  9, 0,  0, 1, 1, 0);
    tbl[10] = mk(0, 0, 0,            0, 0,  0,           0, 0,  9, 0,  0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0,            0, 0,  0,           0, 0,  9, 0,  0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0,            0, 0,  0,           1, 9,  9, 0,  0, 0, 0, 0);
    tbl[13] = mk(1, 9, 32'hA9,       0, 0,  0,           0, 0,  9, 0,  1, 0, 1, 0);
    tbl[14] = mk(0, 0, 0,            0, 0,  0,           1, 9,  9, 0,  0, 0, 1, 0);
    tbl[15] = mk(0, 0, 0,            0, 0,  0,           0, 0,  9, 0,  0, 0, 1, 0);
    tbl[16] = mk(0, 0, 0,            0, 0,  0,           0, 0,  9, 0,  0, 0, 1, 0);
    tbl[17] = mk(1, 0, 32'h1,        0, 0,  0,           1, 0,  9, 0,  1, 0, 1, 0);
    tbl[18] = mk(0, 0, 0,            0, 0,  0,           0, 0,  9, 0,  0, 0, 1, 0);
    tbl[19] = mk(1, 12, 32'hC1,      1, 12, 32'hC2,      0, 0,  9, 12, 0, 1, 1, 0);
    tbl[20] = mk(1, 12, 32'hC1,      0, 0,  0,           0, 0,  9, 12, 1, 0, 1, 0);

    // Reset with both requesters and an issue active: nothing may be accepted.
    reset = 1'b1;
    drive(mk(1, 5, 32'h5, 1, 6, 32'h6, 1, 5, 5, 6, 0, 0, 0, 0));
    #1;
    chk("rst.aReady", aReady, 0);
    chk("rst.bReady", bReady, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.regWrite", regWrite, 0);
    chk("rst.writeReg", writeReg, 0);
    chk("rst.writeData", writeData, 0);
    chk("rst.busy1", busy1, 0);
    chk("rst.busy2", busy2, 0);
    reset = 1'b0;
    last_reg = 7'd0; last_data = 32'd0;

    for (int i = 0; i < 21; i++) cyc($sformatf("vec%0d", i), tbl[i]);

    // Accept a write and claim a register, then reset right after the accept edge.
    drive(mk(1, 7, 32'h77, 0, 0, 0, 1, 7, 7, 9, 1, 0, 0, 0));
    #1;
    chk("midrst.aReady", aReady, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(mk(1, 7, 32'h77, 1, 8, 32'h88, 1, 8, 7, 9, 0, 0, 0, 0));
    #1;
    chk("midrst.aReady_in_reset", aReady, 0);
    chk("midrst.bReady_in_reset", bReady, 0);
    @(posedge clk); #1;
    chk("midrst.regWrite", regWrite, 0);
    chk("midrst.writeReg", writeReg, 0);
    chk("midrst.writeData", writeData, 0);
    chk("midrst.busy1", busy1, 0);
    chk("midrst.busy2", busy2, 0);
    reset = 1'b0;
    exp_q.delete();
    last_reg = 7'd0; last_data = 32'd0;
    cyc("postrst.dual", mk(1, 3, 32'h1234, 1, 4, 32'h5678, 0, 0, 7, 8, 1, 0, 0, 0));
    cyc("postrst.idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 9, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
